// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse cipher core: sizes, FSM states and
// the GF(2^8) arithmetic used by InvMixColumns.
package aes_pkg;

    localparam int unsigned NR     = 10;
    localparam int unsigned BlockW = 128;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StFinal
    } inv_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant, built from repeated doubling.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [BlockW-1:0] inv_mix_columns(input logic [BlockW-1:0] s);
        logic [BlockW-1:0] res;
        logic [7:0]        a [4];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = s[BlockW-1-8*(4*c+i) -: 8];
            end
            for (int i = 0; i < 4; i++) begin
                res[BlockW-1-8*(4*c+i) -: 8] = gf_mul(a[2'(i)], 4'he) ^
                                               gf_mul(a[2'(i + 1)], 4'hb) ^
                                               gf_mul(a[2'(i + 2)], 4'hd) ^
                                               gf_mul(a[2'(i + 3)], 4'h9);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational FIPS-197 inverse S-box lookup.
module inv_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Entry 0 sits in the top byte, so entry k lives at bit offset 8*(255-k).
    localparam logic [2047:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign data_o = InvSbox[{~data_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched
// combinationally through rk_idx_o / rk_i.
module aes_inv_cipher_core #(
    parameter int unsigned NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] ciphertext_i,
    input  logic [127:0] rk_i,
    output logic [3:0]   rk_idx_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] plaintext_o
);

    import aes_pkg::*;

    inv_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BlockW-1:0] st_q, st_d;
    logic [BlockW-1:0] pt_q, pt_d;
    logic              done_q, done_d;
    logic [BlockW-1:0] shifted, subbed, round_out;

    // InvShiftRows: row r rotates right by r columns.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[BlockW-1-8*(4*c+r) -: 8] = st_q[BlockW-1-8*(4*((c-r)&3)+r) -: 8];
            end
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .data_i (shifted[8*i +: 8]),
            .data_o (subbed[8*i +: 8])
        );
    end

    // Shared by ROUND and FINAL; only ROUND follows it with InvMixColumns.
    assign round_out = subbed ^ rk_i;

    always_comb begin
        unique case (state_q)
            StRound: rk_idx_o = cnt_q;
            StFinal: rk_idx_o = 4'd0;
            default: rk_idx_o = 4'(NR);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    st_d    = ciphertext_i ^ rk_i;
                    cnt_d   = 4'(NR - 1);
                    state_d = StRound;
                end
            end
            StRound: begin
                st_d  = inv_mix_columns(round_out);
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                pt_d    = round_out;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            st_q    <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign plaintext_o = pt_q;

endmodule
